// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read feeding a 2-entry {pc, instr} buffer.
// Define IFETCH_MISALIGN_EN to trap misaligned redirects (fetch_err + HALT state).
module instr_fetch #(
  parameter int unsigned MEM_AW   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

`ifdef IFETCH_MISALIGN_EN
  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_FETCH, S_DRAIN} state_e;
`endif

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [1:0]        count_q, count_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              req_q, req_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       pc_q [2];
  logic [31:0]       pc_d [2];
  logic [31:0]       ins_q [2];
  logic [31:0]       ins_d [2];
`ifdef IFETCH_MISALIGN_EN
  logic              err_q, err_d;
`endif

  logic pend, ack_hit, push, pop;

  assign instr_valid = (count_q != 2'd0);
  assign instr       = ins_q[rd_q];
  assign instr_pc    = pc_q[rd_q];
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
`ifdef IFETCH_MISALIGN_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
`ifdef IFETCH_MISALIGN_EN
    err_d      = err_q;
`endif
    pend    = req_q && !mem_ack;
    ack_hit = req_q && mem_ack;
    pop     = instr_valid && instr_ready && !redirect;
    push    = ack_hit && (state_q == S_FETCH) && !redirect;

    if (redirect) begin
      // Flush everything; a still-pending request must be drained, not dropped.
      count_d = 2'd0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      state_d = pend ? S_DRAIN : S_FETCH;
`ifdef IFETCH_MISALIGN_EN
      fetch_pc_d = redirect_pc;
      err_d      = (redirect_pc[1:0] != 2'b00);
      if (err_d && !pend) state_d = S_HALT;
`else
      fetch_pc_d = redirect_pc & ~32'd3;
`endif
    end else begin
      if (push) begin
        pc_d[wr_q]  = fetch_pc_q;
        ins_d[wr_q] = mem_rdata;
        wr_d        = ~wr_q;
        fetch_pc_d  = fetch_pc_q + 32'd4;
      end
      if (pop) rd_d = ~rd_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if ((state_q == S_DRAIN) && ack_hit) begin
`ifdef IFETCH_MISALIGN_EN
        state_d = err_q ? S_HALT : S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
    end

    // Request channel: hold a pending request, otherwise issue when a buffer slot is guaranteed.
    if (pend) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d = (state_d == S_FETCH) && (count_d != 2'd2);
      if (req_d) addr_d = fetch_pc_d[MEM_AW+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      pc_q[0]    <= 32'd0;
      pc_q[1]    <= 32'd0;
      ins_q[0]   <= 32'd0;
      ins_q[1]   <= 32'd0;
`ifdef IFETCH_MISALIGN_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
`ifdef IFETCH_MISALIGN_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
- REQ-001: Parameter MEM_AW, default 8, word-address width of instruction memory.
- REQ-002: Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  asynchronous, active-low reset.
- REQ-005: redirect  input  1  single-cycle request to restart fetch at redirect_pc.
- REQ-006: redirect_pc  input  32  new fetch byte address, sampled when redirect=1.
- REQ-007: mem_req  output  1  memory read request, held until mem_ack.
- REQ-008: mem_addr  output  MEM_AW  word address, equal to fetch_pc[MEM_AW+1:2].
- REQ-009: mem_ack  input  1  memory accepts request; mem_rdata valid in the same cycle.
- REQ-010: mem_rdata  input  32  instruction word returned by memory.
- REQ-011: instr  output  32  head-of-buffer instruction to the decoder.
- REQ-012: instr_pc  output  32  byte address of instr.
- REQ-013: instr_valid  output  1  instr/instr_pc hold a valid entry.
- REQ-014: instr_ready  input  1  consumer accepts the entry when instr_valid=1.
- REQ-015: fetch_err  output  1  sticky misaligned-redirect flag; present only under IFETCH_MISALIGN_EN, tied 0 otherwise.

Function
- REQ-016: The block SHALL contain a 2-entry FIFO of {pc, instr}; instr_valid SHALL equal (count != 0), and instr/instr_pc SHALL be driven from the head entry.
- REQ-017: Pop SHALL occur when instr_valid && instr_ready; a push SHALL occur on mem_ack in FETCH state; a simultaneous push and pop SHALL leave count unchanged.
- REQ-018: At most one request SHALL be outstanding; mem_req SHALL assert only when count + outstanding < 2, counting the same-cycle pop.
- REQ-019: While mem_req=1 and mem_ack=0, mem_addr SHALL remain stable and mem_req SHALL stay high, including across a redirect.
- REQ-020: On every accepted (pushed) response, fetch_pc SHALL advance by 4, wrapping modulo 2^32.
- REQ-021: FSM states SHALL be: FETCH (requests issued per REQ-018), DRAIN (an outstanding request is being completed and its data discarded), HALT (fetch stopped on error).
- REQ-022: FETCH -> DRAIN SHALL occur on redirect while mem_req=1 and mem_ack=0; DRAIN -> FETCH SHALL occur on mem_ack, with the data discarded.
- REQ-023: On redirect, in any state: count SHALL become 0 next cycle, fetch_pc SHALL load redirect_pc, and any same-cycle mem_ack data and pop SHALL be discarded.
- REQ-024: Redirect SHALL take priority over push and pop in the same cycle.
- REQ-025: A redirect received in DRAIN SHALL reload fetch_pc and remain in DRAIN.
- REQ-026: Minimum latency SHALL be 2 cycles, measured from redirect (or reset release) to instr_valid, assuming a zero-wait memory: request in cycle N+1, entry valid in N+2.
- REQ-027: With instr_ready held 1 and a zero-wait memory, sustained throughput SHALL be one instruction per cycle.

Reset
- REQ-028: While rst=0: mem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_err=0, count=0, fetch_pc=RESET_PC, state=FETCH.
- REQ-029: Reset asserted mid-transaction SHALL abandon the outstanding request immediately; the memory is reset by the same signal.
- REQ-030: mem_req SHALL first assert in the first clock edge after rst deasserts.

Configuration
- REQ-031: With IFETCH_MISALIGN_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL set fetch_err, enter HALT (or DRAIN first, if a request is outstanding, then HALT), and issue no requests until an aligned redirect clears fetch_err and returns to FETCH.
- REQ-032: Without IFETCH_MISALIGN_EN, redirect_pc[1:0] SHALL be ignored (treated as 00), fetch_err SHALL be constant 0, and HALT SHALL not exist.

Verification
- REQ-033: Reset release, zero-wait memory returning word = addr, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8 on consecutive cycles from cycle 2.
- REQ-034: instr_ready=0 for 10 cycles -> exactly 2 entries buffered, mem_req=0, instr_pc stays 0x0; then ready=1 -> 0x0, 0x4, 0x8 with no gap or loss.
- REQ-035: Memory with 3-cycle ack latency; redirect to 0x100 during the wait -> mem_addr stable until ack, that data dropped, next request mem_addr=0x40, first instr_pc=0x100.
- REQ-036: Redirect to 0x200 coincident with mem_ack and pop -> count=0 next cycle, no stale entry delivered, first instr_pc=0x200.
- REQ-037: IFETCH_MISALIGN_EN defined, redirect to 0x102 -> fetch_err=1, no mem_req; redirect to 0x104 -> fetch_err=0, instr_pc=0x104.
- REQ-038: Redirect to 0xFFFF_FFFC -> instr_pc 0xFFFF_FFFC then 0x0000_0000 (wrap).
